// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   state_e        : frame controller FSM states
//   ERR_LEN/CHK/TMO: error codes reported on o_err_code
//   SYNC_BYTE_DEF  : default frame start marker
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StPld,
        StChk,
        StDrain
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte timeout counter.
//   i_clk, i_rst : clock, asynchronous active-low reset
//   i_en         : count while a frame is being received
//   i_clr        : byte seen this cycle, restart the count
//   o_expired    : the coming edge would bring the count to TIMEOUT_CYC (single-cycle pulse)
module uart_rx_timeout #(
    parameter int unsigned TIMEOUT_CYC = 10416,
    parameter int unsigned CNT_W       = 14
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A byte on the expiry cycle wins: i_clr masks the pulse.
    always_comb begin
        o_expired = i_en && !i_clr && (cnt_q == LastCnt);
        if (!i_en || i_clr || o_expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver.
// Parses SYNC|LEN|PAYLOAD[LEN]|CHK, buffers the payload, verifies checksum and
// inter-byte timeout, then releases the payload over valid/ready.
//   i_clk, i_rst              : clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid     : byte stream from the UART receiver
//   o_pld_data/valid/last     : payload stream, i_pld_ready accepts
//   o_err_valid, o_err_code   : rejected-frame pulse and held reason code
//   o_drop                    : byte discarded while draining
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYC = 10416,
    parameter int unsigned CNT_W       = 14
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_pld_data,
    output logic       o_pld_valid,
    input  logic       i_pld_ready,
    output logic       o_pld_last,
    output logic       o_err_valid,
    output logic [1:0] o_err_code,
    output logic       o_drop
);

    localparam int unsigned PTR_W      = $clog2(MAX_LEN);
    localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1);
    localparam logic [7:0]  MaxLenByte = 8'(MAX_LEN);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]         sum_q, sum_d;
    logic               pld_valid_q, pld_valid_d;
    logic               err_valid_q, err_valid_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               drop_q, drop_d;
    logic [7:0]         buf_q [MAX_LEN];

    logic               buf_we;
    logic [7:0]         chk_sum;
    logic               wr_last, rd_last;
    logic               tmo_en, tmo_expired;

    assign tmo_en  = state_q inside {StLen, StPld, StChk};
    assign wr_last = (LEN_W'(wr_ptr_q) == len_q - LEN_W'(1));
    assign rd_last = (LEN_W'(rd_ptr_q) == len_q - LEN_W'(1));

    uart_rx_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (tmo_en),
        .i_clr     (i_rx_valid),
        .o_expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sum_d       = sum_q;
        pld_valid_d = pld_valid_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        drop_d      = 1'b0;
        buf_we      = 1'b0;
        chk_sum     = sum_q + i_rx_data;

        unique case (state_q)
            StIdle: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    state_d = StLen;
                end
            end
            StLen: begin
                if (i_rx_valid) begin
                    if ((i_rx_data == 8'd0) || (i_rx_data > MaxLenByte)) begin
                        state_d     = StIdle;
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end else begin
                        len_d    = i_rx_data[LEN_W-1:0];
                        wr_ptr_d = '0;
                        sum_d    = i_rx_data;
                        state_d  = StPld;
                    end
                end
            end
            StPld: begin
                // SYNC_BYTE values are plain data here; no resynchronisation.
                if (i_rx_valid) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + i_rx_data;
                    if (wr_last) begin
                        state_d = StChk;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                end
            end
            StChk: begin
                if (i_rx_valid) begin
                    if (chk_sum == 8'd0) begin
                        state_d     = StDrain;
                        pld_valid_d = 1'b1;
                        rd_ptr_d    = '0;
                    end else begin
                        state_d     = StIdle;
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                end
            end
            StDrain: begin
                drop_d = i_rx_valid;
                if (pld_valid_q && i_pld_ready) begin
                    if (rd_last) begin
                        state_d     = StIdle;
                        pld_valid_d = 1'b0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Only asserted with no byte this cycle, so it never overrides byte handling.
        if (tmo_expired) begin
            state_d     = StIdle;
            err_valid_d = 1'b1;
            err_code_d  = ERR_TMO;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sum_q       <= '0;
            pld_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sum_q       <= sum_d;
            pld_valid_q <= pld_valid_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            drop_q      <= drop_d;
        end
    end

    // Payload storage needs no reset; contents only matter once written.
    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            buf_q[wr_ptr_q] <= i_rx_data;
        end
    end

    assign o_pld_valid = pld_valid_q;
    assign o_pld_data  = pld_valid_q ? buf_q[rd_ptr_q] : 8'd0;
    assign o_pld_last  = pld_valid_q && rd_last;
    assign o_err_valid = err_valid_q;
    assign o_err_code  = err_code_q;
    assign o_drop      = drop_q;

endmodule
